// File: rtl/pwm_gen_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
package pwm_gen_pkg;

    localparam int DEF_CNT_W = 16;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // First phase of a period: HIGH if there is an on-time, else LOW, else nothing to run.
    function automatic state_t start_state(input logic on_nz, input logic off_nz);
        if (on_nz)
            return HIGH;
        else if (off_nz)
            return LOW;
        else
            return IDLE;
    endfunction

endpackage

// File: rtl/pwm_gen_chan.sv
// One PWM channel: pending/active config, IDLE/HIGH/LOW FSM and phase counter.
module pwm_gen_chan
    import pwm_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_on,
    input  logic [CNT_W-1:0] cfg_off,
    input  logic             cfg_oneshot,
    input  logic             ch_en,
    output logic             pwm_out,
    output logic             period_done,
    output logic             ch_active
);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] pend_on, pend_off, act_on, act_off;
    logic [CNT_W-1:0] src_on, src_off;
    logic             pend_os, act_os, src_os;
    logic             os_done, os_done_nx;
    logic             load, end_period;
    logic             pwm_d, done_d;

    // A write landing in the load cycle bypasses the pending regs.
    assign src_on  = cfg_we ? cfg_on      : pend_on;
    assign src_off = cfg_we ? cfg_off     : pend_off;
    assign src_os  = cfg_we ? cfg_oneshot : pend_os;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            pend_on     <= '0;
            pend_off    <= '0;
            pend_os     <= MODE_CONT;
            act_on      <= '0;
            act_off     <= '0;
            act_os      <= MODE_CONT;
            os_done     <= 1'b0;
            pwm_out     <= 1'b0;
            period_done <= 1'b0;
        end else begin
            if (cfg_we) begin
                pend_on  <= cfg_on;
                pend_off <= cfg_off;
                pend_os  <= cfg_oneshot;
            end
            if (load) begin
                act_on  <= src_on;
                act_off <= src_off;
                act_os  <= src_os;
            end
            state       <= state_nx;
            cnt         <= cnt_nx;
            os_done     <= os_done_nx;
            pwm_out     <= pwm_d;
            period_done <= done_d;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        load       = 1'b0;
        end_period = 1'b0;
        os_done_nx = os_done;
        unique case (state)
            IDLE: begin
                load   = 1'b1;
                cnt_nx = '0;
                if (!os_done)
                    state_nx = start_state(src_on != '0, src_off != '0);
            end
            HIGH: begin
                if (cnt == act_on - CNT_W'(1)) begin
                    cnt_nx = '0;
                    if (act_off != '0)
                        state_nx = LOW;
                    else
                        end_period = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            LOW: begin
                if (cnt == act_off - CNT_W'(1)) begin
                    cnt_nx     = '0;
                    end_period = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        if (end_period) begin
            if (act_os == MODE_ONESHOT) begin
                state_nx   = IDLE;
                os_done_nx = 1'b1;
            end else begin
                load     = 1'b1;
                state_nx = start_state(src_on != '0, src_off != '0);
            end
        end
        // Disable wins over everything and also re-arms a finished one-shot.
        if (!ch_en) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            os_done_nx = 1'b0;
        end
    end

    always_comb begin
        pwm_d  = (state_nx == HIGH);
        done_d = end_period && ch_en;
    end

    assign ch_active = (state != IDLE);

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: config write decode plus one pwm_gen_chan per channel.
module pwm_multi_gen
    import pwm_gen_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = DEF_CNT_W,
    parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_on,
    input  logic [CNT_W-1:0] cfg_off,
    input  logic             cfg_oneshot,
    input  logic [NCH-1:0]   ch_en,
    output logic [NCH-1:0]   pwm_out,
    output logic [NCH-1:0]   period_done,
    output logic [NCH-1:0]   ch_active
);

    logic [NCH-1:0] ch_we;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        // Out-of-range selects match no channel and are dropped.
        assign ch_we[g] = cfg_we && (32'(cfg_ch) == 32'(g));

        pwm_gen_chan #(.CNT_W(CNT_W)) u_chan (
            .clk         (clk),
            .reset       (reset),
            .cfg_we      (ch_we[g]),
            .cfg_on      (cfg_on),
            .cfg_off     (cfg_off),
            .cfg_oneshot (cfg_oneshot),
            .ch_en       (ch_en[g]),
            .pwm_out     (pwm_out[g]),
            .period_done (period_done[g]),
            .ch_active   (ch_active[g])
        );
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen: vector table plus hand-written corner sequences.
module tb_pwm_multi_gen;

    localparam int NCH   = 3;
    localparam int CNT_W = 8;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_on, cfg_off;
    logic             cfg_oneshot;
    logic [NCH-1:0]   ch_en;
    logic [NCH-1:0]   pwm_out, period_done, ch_active;

    int checks = 0;
    int errors = 0;

    pwm_multi_gen #(.NCH(NCH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_on      (cfg_on),
        .cfg_off     (cfg_off),
        .cfg_oneshot (cfg_oneshot),
        .ch_en       (ch_en),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .ch_active   (ch_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           we;
        logic [1:0]     ch;
        logic [7:0]     on;
        logic [7:0]     off;
        logic           os;
        logic [NCH-1:0] en;
        logic [NCH-1:0] pwm;
        logic [NCH-1:0] pd;
        logic [NCH-1:0] act;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(input logic we, input int ch, input int on, input int off,
                                input logic [2:0] en, input logic [2:0] pwm,
                                input logic [2:0] pd, input logic [2:0] act);
        vec_t v;
        v.we  = we;
        v.ch  = 2'(ch);
        v.on  = 8'(on);
        v.off = 8'(off);
        v.os  = 1'b0;
        v.en  = en;
        v.pwm = pwm;
        v.pd  = pd;
        v.act = act;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int on, input int off, input logic os);
        cfg_we      = 1'b1;
        cfg_ch      = 2'(ch);
        cfg_on      = 8'(on);
        cfg_off     = 8'(off);
        cfg_oneshot = os;
        step();
        cfg_we      = 1'b0;
    endtask

    int fon[3]  = '{1, 2, 1};
    int foff[3] = '{1, 1, 2};
    int eon[3]  = '{0, 5, 0};
    int eoff[3] = '{5, 0, 0};

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_on = '0; cfg_off = '0;
        cfg_oneshot = 1'b0; ch_en = '0;
        step(); step();
        chk("reset pwm", 32'(pwm_out), 0);
        chk("reset pd", 32'(period_done), 0);
        chk("reset act", 32'(ch_active), 0);
        reset = 1'b0;
        step();
        chk("post-reset act", 32'(ch_active), 0);

        // ch0 3/2 continuous, then disable mid-HIGH and restart from count 0
        tbl[0]  = mk(1, 0, 3, 2, 3'b000, 3'b000, 3'b000, 3'b000);
        tbl[1]  = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b001);
        tbl[2]  = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b001);
        tbl[3]  = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b001);
        tbl[4]  = mk(0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001);
        tbl[5]  = mk(0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001);
        tbl[6]  = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b001, 3'b001);
        tbl[7]  = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b001);
        tbl[8]  = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b001);
        tbl[9]  = mk(0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001);
        tbl[10] = mk(0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001);
        tbl[11] = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b001, 3'b001);
        tbl[12] = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
        tbl[13] = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b001);
        tbl[14] = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b001);
        tbl[15] = mk(0, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b001);
        tbl[16] = mk(0, 0, 0, 0, 3'b001, 3'b000, 3'b000, 3'b001);
        tbl[17] = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 18; i++) begin
            cfg_we = tbl[i].we; cfg_ch = tbl[i].ch; cfg_on = tbl[i].on;
            cfg_off = tbl[i].off; cfg_oneshot = tbl[i].os; ch_en = tbl[i].en;
            step();
            chk($sformatf("vec%0d pwm", i), 32'(pwm_out), 32'(tbl[i].pwm));
            chk($sformatf("vec%0d pd", i), 32'(period_done), 32'(tbl[i].pd));
            chk($sformatf("vec%0d act", i), 32'(ch_active), 32'(tbl[i].act));
        end
        cfg_we = 1'b0;

        // ch1 4/4, rewritten to 10/10 during the first HIGH phase
        wr(1, 4, 4, 1'b0);
        for (int k = 0; k < 28; k++) begin
            ch_en = 3'b010; cfg_we = (k == 2); cfg_ch = 2'd1;
            cfg_on = 8'd10; cfg_off = 8'd10; cfg_oneshot = 1'b0;
            step();
            chk($sformatf("upd k%0d pwm1", k), 32'(pwm_out[1]),
                32'((k < 4) || (k >= 8 && k < 18)));
            chk($sformatf("upd k%0d pd1", k), 32'(period_done[1]), 32'(k == 8));
        end
        cfg_we = 1'b0; ch_en = '0;
        step();

        // ch2 one-shot 2/1, then re-arm through ch_en low
        wr(2, 2, 1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            ch_en = 3'b100;
            step();
            chk($sformatf("os k%0d pwm2", k), 32'(pwm_out[2]), 32'(k < 2));
            chk($sformatf("os k%0d pd2", k), 32'(period_done[2]), 32'(k == 3));
            chk($sformatf("os k%0d act2", k), 32'(ch_active[2]), 32'(k < 3));
        end
        ch_en = 3'b000;
        step();
        chk("os off act2", 32'(ch_active[2]), 0);
        ch_en = 3'b100;
        step();
        chk("os rearm pwm2", 32'(pwm_out[2]), 1);
        ch_en = 3'b000;
        step();

        // degenerate configs on ch0: 0/5, 5/0, 0/0
        for (int c = 0; c < 3; c++) begin
            wr(0, eon[c], eoff[c], 1'b0);
            for (int k = 0; k < 12; k++) begin
                ch_en = 3'b001;
                step();
                chk($sformatf("edge%0d k%0d pwm0", c, k), 32'(pwm_out[0]), 32'(eon[c] != 0));
                chk($sformatf("edge%0d k%0d pd0", c, k), 32'(period_done[0]),
                    32'((eon[c] + eoff[c]) != 0 && k > 0 && k % 5 == 0));
                chk($sformatf("edge%0d k%0d act0", c, k), 32'(ch_active[0]),
                    32'((eon[c] + eoff[c]) != 0));
            end
            ch_en = 3'b000;
            step();
        end

        // reset asserted mid-LOW clears outputs without waiting for a clock
        wr(0, 3, 2, 1'b0);
        ch_en = 3'b001;
        step(); step(); step(); step();
        chk("rst pre pwm0", 32'(pwm_out[0]), 0);
        chk("rst pre act0", 32'(ch_active[0]), 1);
        #1 reset = 1'b1;
        #1;
        chk("rst async pwm", 32'(pwm_out), 0);
        chk("rst async act", 32'(ch_active), 0);
        chk("rst async pd", 32'(period_done), 0);
        step();
        reset = 1'b0;
        step();
        chk("rst cleared cfg act0", 32'(ch_active[0]), 0);
        wr(0, 3, 2, 1'b0);
        chk("rst restart k0", 32'(pwm_out[0]), 1);
        step();
        chk("rst restart k1", 32'(pwm_out[0]), 1);
        step();
        chk("rst restart k2", 32'(pwm_out[0]), 1);
        step();
        chk("rst restart k3", 32'(pwm_out[0]), 0);
        ch_en = 3'b000;
        step();

        // all channels at once; writes to cfg_ch=3 must touch nothing
        for (int c = 0; c < NCH; c++) wr(c, fon[c], foff[c], 1'b0);
        for (int k = 0; k < 24; k++) begin
            ch_en = 3'b111; cfg_we = (k == 3 || k == 9); cfg_ch = 2'd3;
            cfg_on = 8'd7; cfg_off = 8'd7; cfg_oneshot = 1'b1;
            step();
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("multi k%0d pwm%0d", k, c), 32'(pwm_out[c]),
                    32'((k % (fon[c] + foff[c])) < fon[c]));
                chk($sformatf("multi k%0d pd%0d", k, c), 32'(period_done[c]),
                    32'(k > 0 && (k % (fon[c] + foff[c])) == 0));
            end
        end
        cfg_we = 1'b0; ch_en = '0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
